// File: rtl/label_placer_multi.sv
// rtl/label_placer_multi.sv - multi-window text label placer for the video overlay path
module label_placer_multi #(
  parameter int NUM_LABELS = 4,
  parameter int LABEL_LEN  = 8,
  parameter int SCALE      = 0,
  parameter int CW         = 12,
  parameter int IW         = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1,
  parameter int PW         = $clog2(LABEL_LEN)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hs,
  input  logic          vs,
  input  logic          de,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_en,
  input  logic [CW-1:0] cfg_x,
  input  logic [CW-1:0] cfg_y,
  output logic          in_label,
  output logic [IW-1:0] label_id,
  output logic [PW-1:0] place,
  output logic [2:0]    row,
  output logic [2:0]    pixel
);

  // Window compares run wide enough that a label hanging off the right or
  // bottom edge of the raster never wraps back onto low coordinates.
  localparam int WW = CW + PW + 6;
  localparam logic [WW-1:0] WIN_W = WW'(LABEL_LEN * (8 << SCALE));
  localparam logic [WW-1:0] WIN_H = WW'(8 << SCALE);

  logic [CW-1:0] x, y;
  logic          hs_d, vs_d;

  logic          sh_en  [NUM_LABELS];
  logic [CW-1:0] sh_x   [NUM_LABELS];
  logic [CW-1:0] sh_y   [NUM_LABELS];
  logic          act_en [NUM_LABELS];
  logic [CW-1:0] act_x  [NUM_LABELS];
  logic [CW-1:0] act_y  [NUM_LABELS];

  logic          hit_c;
  logic [IW-1:0] id_c;
  logic [PW-1:0] place_c;
  logic [2:0]    row_c, pix_c;
  logic [WW-1:0] xe, ye, xl, yl, dx, dy;

  wire hs_rise = hs & ~hs_d;
  wire vs_rise = vs & ~vs_d;

  // Raster position: vs clears, hs rising starts a new line, de advances; both saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x    <= '0;
      y    <= '0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
      if (vs) begin
        x <= '0;
        y <= '0;
      end else if (hs_rise) begin
        x <= '0;
        if (y != '1) y <= y + CW'(1);
      end else if (de) begin
        if (x != '1) x <= x + CW'(1);
      end
    end
  end

  // Shadow registers take writes any time; active set copies the old shadow at frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
        sh_en[i]  <= 1'b0;
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        act_en[i] <= 1'b0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
      end
    end else begin
      if (cfg_we && (32'(cfg_idx) < NUM_LABELS)) begin
        sh_en[cfg_idx] <= cfg_en;
        sh_x[cfg_idx]  <= cfg_x;
        sh_y[cfg_idx]  <= cfg_y;
      end
      if (vs_rise) begin
        for (int i = 0; i < NUM_LABELS; i++) begin
          act_en[i] <= sh_en[i];
          act_x[i]  <= sh_x[i];
          act_y[i]  <= sh_y[i];
        end
      end
    end
  end

  // Hit test; scanning from the top index down lets the lowest hitting label win.
  always_comb begin
    hit_c   = 1'b0;
    id_c    = '0;
    place_c = '0;
    row_c   = '0;
    pix_c   = '0;
    xe      = {{(WW-CW){1'b0}}, x};
    ye      = {{(WW-CW){1'b0}}, y};
    xl      = '0;
    yl      = '0;
    dx      = '0;
    dy      = '0;
    for (int i = NUM_LABELS - 1; i >= 0; i--) begin
      xl = {{(WW-CW){1'b0}}, act_x[i]};
      yl = {{(WW-CW){1'b0}}, act_y[i]};
      if (de && act_en[i] && (xe >= xl) && (xe < xl + WIN_W) &&
          (ye >= yl) && (ye < yl + WIN_H)) begin
        hit_c   = 1'b1;
        id_c    = IW'(i);
        dx      = xe - xl;
        dy      = ye - yl;
        pix_c   = 3'(dx >> SCALE);
        place_c = PW'(dx >> (SCALE + 3));
        row_c   = 3'(dy >> SCALE);
      end
    end
  end

  // Register the hit result so outputs trail the raster position by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_label <= 1'b0;
      label_id <= '0;
      place    <= '0;
      row      <= '0;
      pixel    <= '0;
    end else begin
      in_label <= hit_c;
      label_id <= id_c;
      place    <= place_c;
      row      <= row_c;
      pixel    <= pix_c;
    end
  end

endmodule

// File: tb/tb_label_placer_multi.sv
// tb/tb_label_placer_multi.sv - directed table-driven bench for label_placer_multi
module tb_label_placer_multi;

  logic       clk = 1'b0;
  logic       rstn, hs, vs, de, cfg_we, cfg_en;
  logic [1:0] cfg_idx;
  logic [11:0] cfg_x, cfg_y;

  logic       in0, in1;
  logic [1:0] id0, id1;
  logic [2:0] pl0, pl1, rw0, rw1, px0, px1;

  int n_chk  = 0;
  int n_fail = 0;
  int cur_x  = 0;

  always #5 clk = ~clk;

  label_placer_multi #(.NUM_LABELS(4), .LABEL_LEN(8), .SCALE(0), .CW(12)) dut0 (
    .clk(clk), .rstn(rstn), .hs(hs), .vs(vs), .de(de),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .in_label(in0), .label_id(id0), .place(pl0), .row(rw0), .pixel(px0)
  );

  label_placer_multi #(.NUM_LABELS(3), .LABEL_LEN(8), .SCALE(1), .CW(12)) dut1 (
    .clk(clk), .rstn(rstn), .hs(hs), .vs(vs), .de(de),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .in_label(in1), .label_id(id1), .place(pl1), .row(rw1), .pixel(px1)
  );

  wire [11:0] out0 = {in0, id0, pl0, rw0, px0};
  wire [11:0] out1 = {in1, id1, pl1, rw1, px1};

  typedef struct {
    bit          sel;
    int          y;
    int          x;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [11:0] mk(bit i, int id, int pl, int rw, int px);
    return {i, 2'(id), 3'(pl), 3'(rw), 3'(px)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got in/id/place/row/pixel=%b expected %b", name, got, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input bit en, input int cx, input int cy);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_en  = en;
    cfg_x   = 12'(cx);
    cfg_y   = 12'(cy);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic start_frame();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    cur_x = 0;
  endtask

  task automatic goto_line(input int n);
    for (int k = 0; k < n; k++) begin
      hs = 1'b1;
      tick();
      hs = 1'b0;
      tick();
    end
    cur_x = 0;
  endtask

  // Advance with de=1 so that the last cycle driven presents x=target.
  task automatic run_to(input int target);
    while (cur_x <= target) begin
      de = 1'b1;
      tick();
      cur_x++;
    end
    de = 1'b0;
  endtask

  initial begin
    bit seen;

    rstn = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;

    vecs[0]  = '{0, 20,  99, mk(0,0,0,0,0)};
    vecs[1]  = '{0, 20, 100, mk(1,0,0,0,0)};
    vecs[2]  = '{0, 20, 109, mk(1,0,1,0,1)};
    vecs[3]  = '{0, 20, 163, mk(1,0,7,0,7)};
    vecs[4]  = '{0, 20, 164, mk(0,0,0,0,0)};
    vecs[5]  = '{0, 27, 100, mk(1,0,0,7,0)};
    vecs[6]  = '{0, 28, 100, mk(0,0,0,0,0)};
    vecs[7]  = '{0,  5,  45, mk(1,1,1,0,0)};
    vecs[8]  = '{1,  5,  37, mk(1,1,0,0,0)};
    vecs[9]  = '{1,  5,  38, mk(1,1,0,0,0)};
    vecs[10] = '{1,  5,  53, mk(1,1,1,0,0)};
    vecs[11] = '{1,  5,  36, mk(0,0,0,0,0)};
    vecs[12] = '{1, 20,  37, mk(1,1,0,7,0)};
    vecs[13] = '{1, 21,  37, mk(0,0,0,0,0)};
    vecs[14] = '{1, 20, 120, mk(1,0,1,0,2)};

    tick();
    tick();
    chk("reset_dut0", out0, 12'h000);
    chk("reset_dut1", out1, 12'h000);
    rstn = 1'b1;
    tick();

    cfg_write(0, 1, 100, 20);
    cfg_write(1, 1, 37, 5);

    for (int v = 0; v < 15; v++) begin
      start_frame();
      goto_line(vecs[v].y);
      run_to(vecs[v].x);
      chk($sformatf("vec%0d_y%0d_x%0d", v, vecs[v].y, vecs[v].x),
          vecs[v].sel ? out1 : out0, vecs[v].exp);
      tick();
    end

    // Reset asserted mid-line inside a hit clears outputs without a clock edge.
    start_frame();
    goto_line(20);
    run_to(100);
    chk("pre_reset_hit", out0, mk(1,0,0,0,0));
    de   = 1'b1;
    rstn = 1'b0;
    #1;
    chk("async_reset_dut0", out0, 12'h000);
    chk("async_reset_dut1", out1, 12'h000);
    tick();
    tick();
    de   = 1'b0;
    rstn = 1'b1;
    tick();
    start_frame();
    goto_line(20);
    seen = 1'b0;
    for (int k = 0; k <= 200; k++) begin
      de = 1'b1;
      tick();
      if (in0 || in1) seen = 1'b1;
    end
    de = 1'b0;
    chk("idle_after_reset", {11'b0, seen}, 12'h000);

    // Overlap priority.
    cfg_write(0, 1, 180, 40);
    cfg_write(2, 1, 190, 36);
    start_frame();
    goto_line(40);
    run_to(200);
    chk("overlap_lowest_wins", out0, mk(1,0,2,0,4));
    cfg_write(0, 0, 180, 40);
    start_frame();
    goto_line(40);
    run_to(200);
    chk("overlap_label2", out0, mk(1,2,1,4,2));

    // Double buffering.
    cfg_write(0, 1, 180, 40);
    cfg_write(2, 0, 190, 36);
    start_frame();
    goto_line(40);
    cfg_write(0, 1, 300, 40);
    run_to(180);
    chk("dbuf_old_pos_hit", out0, mk(1,0,0,0,0));
    run_to(300);
    chk("dbuf_new_pos_miss", out0, 12'h000);

    cfg_we  = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_x = 12'd400; cfg_y = 12'd40;
    vs = 1'b1;
    tick();
    cfg_we = 1'b0;
    vs = 1'b0;
    tick();
    cur_x = 0;
    goto_line(40);
    run_to(180);
    chk("dbuf_commit_old_miss", out0, 12'h000);
    run_to(300);
    chk("dbuf_commit_hit", out0, mk(1,0,0,0,0));
    start_frame();
    goto_line(40);
    run_to(300);
    chk("dbuf_coincident_300_miss", out0, 12'h000);
    run_to(400);
    chk("dbuf_coincident_400_hit", out0, mk(1,0,0,0,0));

    // Index 3 is a real label on dut0 but out of range on dut1.
    cfg_write(3, 1, 0, 0);
    start_frame();
    run_to(10);
    chk("idx3_dut0_hit", out0, mk(1,3,1,0,2));
    chk("idx_oob_dut1_ignored", out1, 12'h000);
    tick();

    // Right edge: window runs past 4095 without wrapping, x saturates.
    cfg_write(1, 1, 4090, 50);
    start_frame();
    goto_line(50);
    run_to(57);
    chk("edge_no_wrap", out0, 12'h000);
    run_to(4090);
    chk("edge_first", out0, mk(1,1,0,0,0));
    run_to(4095);
    chk("edge_last", out0, mk(1,1,0,0,5));
    de = 1'b1;
    tick();
    chk("x_saturates", out0, mk(1,1,0,0,5));
    de = 1'b0;
    tick();
    chk("de_low_in_window", out0, 12'h000);
    de = 1'b1;
    tick();
    chk("x_held_de_low", out0, mk(1,1,0,0,5));
    de = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
